keypad_scan_fsm: RTL and testbench
==================================

Name: keypad_scan_fsm

Overview:
- Upstream stage of the keypad decoder.
- Drives the 4x4 keypad columns one-hot and samples the rows through a 2-flop synchronizer.
- Debounces presses and releases; emits a one-cycle keyValid pulse per press, with the latched one-hot storedCol/storedRow that the decoder turns into a hex digit.
- One key is registered per press; no auto-repeat.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven while scanning (>=4)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (>=2)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  asynchronous, active-high reset
rowIn  input  4  raw keypad rows, active-high, asynchronous to clk
colOut  output  4  one-hot active-high column drive
storedCol  output  4  column of last accepted key, one-hot; feeds the decoder
storedRow  output  4  row of last accepted key, one-hot; feeds the decoder
keyValid  output  1  one-cycle pulse when storedCol/storedRow update
keyHeld  output  1  high from acceptance until the debounced release completes

Behaviour:
- Reset (async, active-high) sets:
  - colOut=4'b0001, storedCol=0, storedRow=0, keyValid=0, keyHeld=0.
  - Synchronizer flops=0, all counters=0, state=SCAN.
- Sync: syncRow = rowIn after 2 flops (2-cycle latency). All decisions use syncRow only.
- rowValid = syncRow has exactly one bit set. A value of 0 or multiple bits counts as no key.
- Counters: scanCnt and dbCnt are each $clog2 of their parameter wide. Neither may wrap.
- SCAN:
  - scanCnt increments each cycle.
  - When scanCnt==SCAN_DIV-1:
    - If rowValid: go to DEBOUNCE, candRow<=syncRow, dbCnt<=0, colOut frozen.
    - Else: scanCnt<=0, colOut rotates 0001->0010->0100->1000->0001.
  - A row seen earlier in the dwell is ignored; this allows settling time.
- DEBOUNCE:
  - If syncRow==candRow: dbCnt++.
  - Else: back to SCAN with scanCnt<=0 and the same column (no rotate).
  - At dbCnt==DEBOUNCE_CYCLES-1 with a match: go to PRESSED.
- PRESSED (exactly 1 cycle):
  - storedCol<=colOut and storedRow<=candRow, registered so they are valid the same cycle keyValid=1.
  - keyHeld=1. Next state is HELD.
- HELD:
  - keyHeld=1, colOut frozen.
  - dbCnt counts consecutive cycles with syncRow==0 and clears to 0 on any nonzero syncRow.
  - At dbCnt==DEBOUNCE_CYCLES-1: go to SCAN, keyHeld<=0, scanCnt<=0, colOut rotates to the next column.
- Held-key and outputs:
  - Keys in other columns are invisible while HELD; they are ignored.
  - A held key never re-triggers.
  - storedCol/storedRow hold their value until the next accepted press. They are never cleared except by reset.
- keyValid is high only in the PRESSED cycle and is never high for 2 consecutive cycles.
- Reset mid-operation (any state) takes effect immediately and returns all outputs to their reset values; a pending press is discarded.
- colOut is always one-hot after reset.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
1. Clean press: idle rowIn=0; when colOut=4'b0100, drive rowIn=4'b0001 for 40 cycles, then 0 -> exactly one keyValid pulse; storedCol=4'b0100, storedRow=4'b0001 (decoder gives 3); keyHeld high until 8 cycles of synced zero, then scanning resumes at colOut=4'b1000.
2. Bounce: when colOut=4'b0001, toggle rowIn between 4'b0010 and 0 every 3 cycles for 30 cycles -> no keyValid; storedCol/storedRow stay at their previous values; scan resumes.
3. Release glitch: after acceptance, release then pulse rowIn nonzero for 2 cycles at release cycle 5 -> keyHeld stays high, the release count restarts, no second keyValid.
4. Multi-row: rowIn=4'b0011 on any column -> never leaves SCAN; colOut keeps rotating every 4 cycles; no keyValid.
5. Reset mid-HELD: accept key (col 4'b0010, row 4'b1000 = 0), then assert reset -> colOut=4'b0001, storedCol=0, storedRow=0, keyHeld=0, keyValid=0 immediately (async, before the next clk edge).
6. Two sequential keys: press col 4'b1000/row 4'b0100, release, then press col 4'b0001/row 4'b0001 -> two keyValid pulses with storedCol/storedRow = 1000/0100 (c) then 0001/0001 (1).

Source files
------------

// File: rtl/keypad_scan_fsm.sv
// 4x4 keypad column scanner with row synchronizer and press/release debounce.
// Emits a one-cycle keyValid pulse with the latched one-hot column/row of each accepted key.
module keypad_scan_fsm #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rowIn,
  output logic [3:0] colOut,
  output logic [3:0] storedCol,
  output logic [3:0] storedRow,
  output logic       keyValid,
  output logic       keyHeld
);

  // state      | meaning
  // S_SCAN     | rotate column drive, sample rows at the end of each dwell
  // S_DEBOUNCE | candidate row must stay identical for DEBOUNCE_CYCLES
  // S_PRESSED  | single cycle: stored key valid, keyValid pulses
  // S_HELD     | wait for DEBOUNCE_CYCLES consecutive all-zero rows

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_HELD     = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [3:0]        r_cand_row;
  logic [3:0]        r_col;
  logic [3:0]        r_stored_col;
  logic [3:0]        r_stored_row;
  logic              r_key_valid;
  logic              r_key_held;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [DB_W-1:0]   r_db_cnt;

  logic              w_row_valid;
  logic [3:0]        w_col_next;

  // Exactly one row bit set; zero or multiple simultaneous rows count as no key.
  assign w_row_valid = (r_sync2 != 4'd0) && ((r_sync2 & (r_sync2 - 4'd1)) == 4'd0);
  assign w_col_next  = {r_col[2:0], r_col[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= rowIn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_SCAN;
      r_cand_row   <= 4'd0;
      r_col        <= 4'b0001;
      r_stored_col <= 4'd0;
      r_stored_row <= 4'd0;
      r_key_valid  <= 1'b0;
      r_key_held   <= 1'b0;
      r_scan_cnt   <= '0;
      r_db_cnt     <= '0;
    end else begin
      case (r_state)
        S_SCAN: begin
          // Rows are only judged at the end of the dwell so the column drive can settle.
          if (r_scan_cnt == SCAN_LAST) begin
            if (w_row_valid) begin
              r_state    <= S_DEBOUNCE;
              r_cand_row <= r_sync2;
              r_db_cnt   <= '0;
            end else begin
              r_scan_cnt <= '0;
              r_col      <= w_col_next;
            end
          end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
        end

        S_DEBOUNCE: begin
          if (r_sync2 == r_cand_row) begin
            if (r_db_cnt == DB_LAST) begin
              r_state      <= S_PRESSED;
              r_stored_col <= r_col;
              r_stored_row <= r_cand_row;
              r_key_valid  <= 1'b1;
              r_key_held   <= 1'b1;
            end else begin
              r_db_cnt <= r_db_cnt + 1'b1;
            end
          end else begin
            // Bounce: retry the same column from the start of its dwell.
            r_state    <= S_SCAN;
            r_scan_cnt <= '0;
          end
        end

        S_PRESSED: begin
          r_state     <= S_HELD;
          r_key_valid <= 1'b0;
          r_db_cnt    <= '0;
        end

        S_HELD: begin
          if (r_sync2 == 4'd0) begin
            if (r_db_cnt == DB_LAST) begin
              r_state    <= S_SCAN;
              r_key_held <= 1'b0;
              r_scan_cnt <= '0;
              r_col      <= w_col_next;
            end else begin
              r_db_cnt <= r_db_cnt + 1'b1;
            end
          end else begin
            r_db_cnt <= '0;
          end
        end

        default: begin
          r_state     <= S_SCAN;
          r_key_valid <= 1'b0;
          r_key_held  <= 1'b0;
          r_scan_cnt  <= '0;
          r_col       <= 4'b0001;
        end
      endcase
    end
  end

  assign colOut    = r_col;
  assign storedCol = r_stored_col;
  assign storedRow = r_stored_row;
  assign keyValid  = r_key_valid;
  assign keyHeld   = r_key_held;

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Directed bench for keypad_scan_fsm with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// Press scenarios come from a vector table; glitch, bounce, multi-row and reset cases are hand-written.
module tb_keypad_scan_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rowIn;
  logic [3:0] colOut;
  logic [3:0] storedCol;
  logic [3:0] storedRow;
  logic       keyValid;
  logic       keyHeld;

  int checks = 0;
  int errors = 0;
  int kv_count = 0;
  int kv_double = 0;
  int oh_bad = 0;
  logic kv_prev = 1'b0;

  keypad_scan_fsm #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .rowIn(rowIn),
    .colOut(colOut),
    .storedCol(storedCol),
    .storedRow(storedRow),
    .keyValid(keyValid),
    .keyHeld(keyHeld)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (keyValid) kv_count <= kv_count + 1;
    if (keyValid && kv_prev) kv_double <= kv_double + 1;
    kv_prev <= keyValid;
    if (!reset && !$onehot(colOut)) oh_bad <= oh_bad + 1;
  end

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
    int         hold;
    int         exp_pulses;
    logic [3:0] exp_col;
    logic [3:0] exp_row;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [3:0] rot(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at the first negedge where colOut has just switched to col.
  task automatic wait_col_enter(input logic [3:0] col, output logic ok);
    logic [3:0] prev;
    prev = colOut;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (colOut == col && prev != col) begin
        ok = 1'b1;
        break;
      end
      prev = colOut;
    end
  endtask

  // Edges from driving rowIn=0 until keyHeld is seen low.
  task automatic count_release(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (!keyHeld) break;
    end
  endtask

  initial begin
    logic ok;
    int   base;
    int   n;
    logic [3:0] cur;

    vecs[0] = '{col: 4'b0100, row: 4'b0001, hold: 40, exp_pulses: 1, exp_col: 4'b0100, exp_row: 4'b0001};
    vecs[1] = '{col: 4'b1000, row: 4'b0100, hold: 30, exp_pulses: 1, exp_col: 4'b1000, exp_row: 4'b0100};
    vecs[2] = '{col: 4'b0001, row: 4'b0001, hold: 30, exp_pulses: 1, exp_col: 4'b0001, exp_row: 4'b0001};
    vecs[3] = '{col: 4'b0010, row: 4'b0011, hold: 20, exp_pulses: 0, exp_col: 4'b0001, exp_row: 4'b0001};
    vecs[4] = '{col: 4'b1000, row: 4'b0010, hold: 6,  exp_pulses: 0, exp_col: 4'b0001, exp_row: 4'b0001};
    vecs[5] = '{col: 4'b0010, row: 4'b1000, hold: 30, exp_pulses: 1, exp_col: 4'b0010, exp_row: 4'b1000};
    vecs[6] = '{col: 4'b0100, row: 4'b0000, hold: 20, exp_pulses: 0, exp_col: 4'b0010, exp_row: 4'b1000};

    reset = 1'b1;
    rowIn = 4'd0;
    #1;
    check("rst_colOut", 32'(colOut), 32'h1);
    check("rst_storedCol", 32'(storedCol), 32'h0);
    check("rst_storedRow", 32'(storedRow), 32'h0);
    check("rst_keyValid", 32'(keyValid), 32'h0);
    check("rst_keyHeld", 32'(keyHeld), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      base = kv_count;
      wait_col_enter(vecs[v].col, ok);
      check($sformatf("v%0d_col_found", v), 32'(ok), 32'h1);
      rowIn = vecs[v].row;
      repeat (vecs[v].hold) @(negedge clk);
      if (vecs[v].exp_pulses != 0) begin
        check($sformatf("v%0d_held_before_release", v), 32'(keyHeld), 32'h1);
        rowIn = 4'd0;
        count_release(n);
        check($sformatf("v%0d_release_edges", v), 32'(n), 32'd10);
        check($sformatf("v%0d_resume_col", v), 32'(colOut), 32'(rot(vecs[v].col)));
      end else begin
        rowIn = 4'd0;
        repeat (30) @(negedge clk);
      end
      check($sformatf("v%0d_pulses", v), 32'(kv_count - base), 32'(vecs[v].exp_pulses));
      check($sformatf("v%0d_storedCol", v), 32'(storedCol), 32'(vecs[v].exp_col));
      check($sformatf("v%0d_storedRow", v), 32'(storedRow), 32'(vecs[v].exp_row));
    end

    // Release glitch: nonzero rows at release cycle 5 restart the release count.
    base = kv_count;
    wait_col_enter(4'b0001, ok);
    check("glitch_col_found", 32'(ok), 32'h1);
    rowIn = 4'b0100;
    repeat (30) @(negedge clk);
    rowIn = 4'd0;
    repeat (5) @(negedge clk);
    rowIn = 4'b0100;
    repeat (2) @(negedge clk);
    check("glitch_still_held", 32'(keyHeld), 32'h1);
    rowIn = 4'd0;
    count_release(n);
    check("glitch_release_edges", 32'(n), 32'd10);
    check("glitch_pulses", 32'(kv_count - base), 32'd1);
    check("glitch_storedCol", 32'(storedCol), 32'h1);
    check("glitch_storedRow", 32'(storedRow), 32'h4);
    check("glitch_resume_col", 32'(colOut), 32'h2);

    // Bounce: toggling every 3 cycles never survives debounce.
    base = kv_count;
    wait_col_enter(4'b0001, ok);
    check("bounce_col_found", 32'(ok), 32'h1);
    for (int i = 0; i < 10; i++) begin
      rowIn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (3) @(negedge clk);
    end
    rowIn = 4'd0;
    repeat (20) @(negedge clk);
    check("bounce_pulses", 32'(kv_count - base), 32'd0);
    check("bounce_storedCol", 32'(storedCol), 32'h1);
    check("bounce_storedRow", 32'(storedRow), 32'h4);
    cur = colOut;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (colOut != cur) begin
        ok = 1'b1;
        break;
      end
    end
    check("bounce_scan_resumes", 32'(ok), 32'h1);

    // Multi-row: columns keep rotating every 4 cycles.
    base = kv_count;
    rowIn = 4'b0011;
    cur = colOut;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (colOut != cur) begin
        ok = 1'b1;
        break;
      end
    end
    check("multi_first_rotate", 32'(ok), 32'h1);
    for (int k = 0; k < 4; k++) begin
      cur = colOut;
      n = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        n++;
        if (colOut != cur) break;
      end
      check($sformatf("multi_dwell%0d", k), 32'(n), 32'd4);
      check($sformatf("multi_next%0d", k), 32'(colOut), 32'(rot(cur)));
    end
    rowIn = 4'd0;
    check("multi_pulses", 32'(kv_count - base), 32'd0);

    // Reset while HELD clears everything before the next clock edge.
    wait_col_enter(4'b0010, ok);
    check("rstheld_col_found", 32'(ok), 32'h1);
    rowIn = 4'b1000;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (keyValid) begin
        ok = 1'b1;
        break;
      end
    end
    check("rstheld_keyValid_seen", 32'(ok), 32'h1);
    check("rstheld_storedCol", 32'(storedCol), 32'h2);
    check("rstheld_storedRow", 32'(storedRow), 32'h8);
    repeat (3) @(negedge clk);
    check("rstheld_keyHeld", 32'(keyHeld), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rstheld_colOut", 32'(colOut), 32'h1);
    check("rstheld_storedCol_clr", 32'(storedCol), 32'h0);
    check("rstheld_storedRow_clr", 32'(storedRow), 32'h0);
    check("rstheld_keyHeld_clr", 32'(keyHeld), 32'h0);
    check("rstheld_keyValid_clr", 32'(keyValid), 32'h0);
    rowIn = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    check("keyValid_never_double", 32'(kv_double), 32'd0);
    check("colOut_onehot", 32'(oh_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
